// File: rtl/legv8_instr_encoder_if.sv
// Command/instruction bus for the LEGv8 encoder: field-level commands in, encoded words out.
// Both channels transfer exactly on a rising edge where valid && ready; valid may not depend on ready.
interface legv8_instr_encoder_if #(
  parameter int ADDR_W = 16
);
  logic              flush;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rn;
  logic [4:0]        cmd_rm;
  logic [25:0]       cmd_imm;
  logic [3:0]        cmd_cond;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr_word;
  logic [ADDR_W-1:0] instr_addr;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output flush, cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, cmd_cond, instr_ready,
    input  cmd_ready, instr_valid, instr_word, instr_addr, err, err_code
  );

  modport slave (
    input  flush, cmd_valid, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_imm, cmd_cond, instr_ready,
    output cmd_ready, instr_valid, instr_word, instr_addr, err, err_code
  );
endinterface

// File: rtl/legv8_instr_encoder.sv
// Encodes field-level LEGv8 commands into 32-bit words, buffers them in a FIFO and
// streams them out with sequential byte addresses. Out-of-range commands are dropped and flagged.
module legv8_instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  legv8_instr_encoder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wrPtr, rdPtr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addrQ;
  logic              errQ;
  logic [1:0]        errCodeQ;

  logic [31:0] encWord;
  logic [1:0]  encErr;
  logic        fits19, fits9, fits12u;
  logic        accept, push, reject, pop;

  // A signed field fits when every bit above its sign bit repeats the sign bit.
  assign fits19  = (&bus.cmd_imm[25:18]) | ~(|bus.cmd_imm[25:18]);
  assign fits9   = (&bus.cmd_imm[25:8])  | ~(|bus.cmd_imm[25:8]);
  assign fits12u = ~(|bus.cmd_imm[25:12]);

  always_comb begin
    encWord = '0;
    encErr  = 2'd0;
    case (bus.cmd_op)
      4'd0: encWord = {6'b000101, bus.cmd_imm};
      4'd1: begin
        encWord = {8'b01010100, bus.cmd_imm[18:0], 1'b0, bus.cmd_cond};
        if (!fits19) encErr = 2'd2;
      end
      4'd2: encWord = {6'b100101, bus.cmd_imm};
      4'd3: encWord = {11'b11010110000, 5'b11111, 6'b000000, bus.cmd_rn, 5'b00000};
      4'd4: begin
        encWord = {8'b10110100, bus.cmd_imm[18:0], bus.cmd_rd};
        if (!fits19) encErr = 2'd2;
      end
      4'd5: begin
        encWord = {10'b1001000100, bus.cmd_imm[11:0], bus.cmd_rn, bus.cmd_rd};
        if (!fits12u) encErr = 2'd2;
      end
      4'd6: encWord = {11'b10101011000, bus.cmd_rm, 6'b000000, bus.cmd_rn, bus.cmd_rd};
      4'd7: begin
        encWord = {11'b11111000010, bus.cmd_imm[8:0], 2'b00, bus.cmd_rn, bus.cmd_rd};
        if (!fits9) encErr = 2'd2;
      end
      4'd8: begin
        encWord = {11'b11111000000, bus.cmd_imm[8:0], 2'b00, bus.cmd_rn, bus.cmd_rd};
        if (!fits9) encErr = 2'd2;
      end
      4'd9: encWord = {11'b11101011000, bus.cmd_rm, 6'b000000, bus.cmd_rn, bus.cmd_rd};
      default: encErr = 2'd1;
    endcase
  end

  // Rejected commands are still handshaken so the producer never stalls on a bad command.
  assign bus.cmd_ready   = rst && (count != CNT_W'(DEPTH));
  assign accept          = bus.cmd_valid && bus.cmd_ready;
  assign push            = accept && (encErr == 2'd0);
  assign reject          = accept && (encErr != 2'd0);
  assign bus.instr_valid = (count != '0);
  assign pop             = bus.instr_valid && bus.instr_ready;

  assign bus.instr_word = mem[rdPtr];
  assign bus.instr_addr = addrQ;
  assign bus.err        = errQ;
  assign bus.err_code   = errCodeQ;

  always_ff @(posedge clk) begin
    if (rst && !bus.flush && push) mem[wrPtr] <= encWord;
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      addrQ    <= BASE_ADDR;
      errQ     <= 1'b0;
      errCodeQ <= 2'd0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        addrQ <= addrQ + ADDR_W'(4);
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (reject) begin
        errQ     <= 1'b1;
        errCodeQ <= encErr;
      end
    end
  end
endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Bench for legv8_instr_encoder: directed vector table, hand sequences for full/flush/wrap,
// and random commands scored against an arithmetic encoding model.
module tb_legv8_instr_encoder;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   failed    = 0;
  int   readyMode = 1;  // 0 hold low, 1 hold high, 2 random
  logic [31:0] exp_q[$];
  logic [15:0] tbAddr = 16'd0;
  logic        tbErr  = 1'b0;
  logic [1:0]  tbCode = 2'd0;

  legv8_instr_encoder_if #(.ADDR_W(16)) bus ();
  legv8_instr_encoder_if #(.ADDR_W(4))  bus2 ();

  legv8_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(16), .BASE_ADDR(16'd0)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  legv8_instr_encoder #(.DEPTH(2), .ADDR_W(4), .BASE_ADDR(4'd0)) dutWrap (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    int          op, rd, rn, rm, imm, cond;
    logic [31:0] w;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[16];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder built from opcode base values plus shifted fields.
  function automatic void model(input int op, rd, rn, rm, imm, cond,
                                output logic [31:0] w, output logic [1:0] code);
    longint v;
    v = 0;
    code = 2'd0;
    case (op)
      0: v = 64'h14000000 + (imm & 32'h03FFFFFF);
      1: begin
        v = 64'h54000000 + (longint'(imm & 32'h7FFFF) * 32) + cond;
        if (imm < -(1 << 18) || imm > (1 << 18) - 1) code = 2'd2;
      end
      2: v = 64'h94000000 + (imm & 32'h03FFFFFF);
      3: v = 64'hD61F0000 + rn * 32;
      4: begin
        v = 64'hB4000000 + (longint'(imm & 32'h7FFFF) * 32) + rd;
        if (imm < -(1 << 18) || imm > (1 << 18) - 1) code = 2'd2;
      end
      5: begin
        v = 64'h91000000 + (longint'(imm & 32'hFFF) * 1024) + rn * 32 + rd;
        if (imm < 0 || imm > 4095) code = 2'd2;
      end
      6: v = 64'hAB000000 + rm * 65536 + rn * 32 + rd;
      7, 8: begin
        v = (op == 7 ? 64'hF8400000 : 64'hF8000000) + (longint'(imm & 32'h1FF) * 4096) + rn * 32 + rd;
        if (imm < -256 || imm > 255) code = 2'd2;
      end
      9: v = 64'hEB000000 + rm * 65536 + rn * 32 + rd;
      default: code = 2'd1;
    endcase
    w = v[31:0];
  endfunction

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic send(input int op, rd, rn, rm, imm, cond,
                      input logic [31:0] expW, input logic [1:0] expCode);
    int cyc;
    logic [25:0] immBits;
    immBits      = imm[25:0];
    bus.cmd_op   = op[3:0];
    bus.cmd_rd   = rd[4:0];
    bus.cmd_rn   = rn[4:0];
    bus.cmd_rm   = rm[4:0];
    bus.cmd_imm  = immBits;
    bus.cmd_cond = cond[3:0];
    bus.cmd_valid = 1'b1;
    cyc = 0;
    while (!bus.cmd_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    if (expCode == 2'd0) exp_q.push_back(expW);
    else begin
      tbErr  = 1'b1;
      tbCode = expCode;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("err", {31'd0, bus.err}, {31'd0, tbErr});
    check("err_code", {30'd0, bus.err_code}, {30'd0, tbCode});
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    exp_q.delete();
    tbAddr = 16'd0;
    tbErr  = 1'b0;
    tbCode = 2'd0;
    check("flush_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("flush_addr", {16'd0, bus.instr_addr}, 32'd0);
    check("flush_err", {31'd0, bus.err}, 32'd0);
  endtask

  task automatic drain();
    int cyc;
    readyMode = 1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 32'd0);
    check("drain_valid_low", {31'd0, bus.instr_valid}, 32'd0);
  endtask

  // ---------------- consumer ready driver ----------------
  initial begin
    bus.instr_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.instr_ready = (readyMode == 1) || (readyMode == 2 && $urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst && !bus.flush && bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", bus.instr_word, 32'hFFFFFFFF);
        end else begin
          check("instr_word", bus.instr_word, exp_q.pop_front());
          check("instr_addr", {16'd0, bus.instr_addr}, {16'd0, tbAddr});
          tbAddr = tbAddr + 16'd4;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] w;
    logic [1:0]  code;
    int          op, imm, cyc;

    vecs[0]  = '{5, 1, 2, 0, 5, 0, 32'h91001441, 2'd0};
    vecs[1]  = '{7, 3, 4, 0, -8, 0, 32'hF85F8083, 2'd0};
    vecs[2]  = '{3, 0, 30, 0, 0, 0, 32'hD61F03C0, 2'd0};
    vecs[3]  = '{0, 0, 0, 0, -1, 0, 32'h17FFFFFF, 2'd0};
    vecs[4]  = '{4, 5, 0, 0, 2, 0, 32'hB4000045, 2'd0};
    vecs[5]  = '{9, 9, 10, 11, 0, 0, 32'hEB0B0149, 2'd0};
    vecs[6]  = '{5, 1, 2, 0, 4096, 0, 32'h0, 2'd2};
    vecs[7]  = '{12, 1, 2, 3, 0, 0, 32'h0, 2'd1};
    vecs[8]  = '{6, 1, 2, 3, 0, 0, 32'hAB030041, 2'd0};
    vecs[9]  = '{8, 7, 8, 0, 255, 0, 32'hF80FF107, 2'd0};
    vecs[10] = '{2, 0, 0, 0, 256, 0, 32'h94000100, 2'd0};
    vecs[11] = '{1, 0, 0, 0, -(1 << 18), 1, 32'h54800001, 2'd0};
    vecs[12] = '{4, 0, 0, 0, 1 << 18, 0, 32'h0, 2'd2};
    vecs[13] = '{7, 0, 0, 0, -257, 0, 32'h0, 2'd2};
    vecs[14] = '{5, 0, 0, 0, 4095, 0, 32'h913FFC00, 2'd0};
    vecs[15] = '{8, 0, 0, 0, 256, 0, 32'h0, 2'd2};

    rst = 1'b0;
    bus.flush = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rn = '0; bus.cmd_rm = '0;
    bus.cmd_imm = '0; bus.cmd_cond = '0;
    bus2.flush = 1'b0; bus2.cmd_valid = 1'b0; bus2.instr_ready = 1'b0;
    bus2.cmd_op = '0; bus2.cmd_rd = '0; bus2.cmd_rn = '0; bus2.cmd_rm = '0;
    bus2.cmd_imm = '0; bus2.cmd_cond = '0;
    readyMode = 1;

    repeat (3) @(negedge clk);
    check("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("reset_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("reset_instr_addr", {16'd0, bus.instr_addr}, 32'd0);
    check("reset_err", {31'd0, bus.err}, 32'd0);
    check("reset_err_code", {30'd0, bus.err_code}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // One-cycle latency from accept to a valid head when the FIFO was empty.
    send(vecs[0].op, vecs[0].rd, vecs[0].rn, vecs[0].rm, vecs[0].imm, vecs[0].cond, vecs[0].w, vecs[0].code);
    check("latency_valid", {31'd0, bus.instr_valid}, 32'd1);

    for (int i = 1; i < 16; i++)
      send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].cond, vecs[i].w, vecs[i].code);
    drain();

    // Backpressure: fill the FIFO, hold one command pending, then release the consumer.
    readyMode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      model(5, i, 1, 0, i * 3, 0, w, code);
      send(5, i, 1, 0, i * 3, 0, w, code);
    end
    check("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("full_instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    model(6, 4, 5, 6, 0, 0, w, code);
    fork
      send(6, 4, 5, 6, 0, 0, w, code);
      begin
        repeat (3) @(negedge clk);
        check("full_hold_ready", {31'd0, bus.cmd_ready}, 32'd0);
        readyMode = 1;
      end
    join
    drain();

    // Flush mid-stream drops buffered words and restarts addresses.
    readyMode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      model(0, 0, 0, 0, i + 100, 0, w, code);
      send(0, 0, 0, 0, i + 100, 0, w, code);
    end
    send(13, 0, 0, 0, 0, 0, 32'h0, 2'd1);
    do_flush();
    readyMode = 1;
    model(4, 7, 0, 0, -4, 0, w, code);
    send(4, 7, 0, 0, -4, 0, w, code);
    drain();

    // Address wrap on a 4-bit address instance.
    for (int i = 0; i < 5; i++) begin
      bus2.cmd_op = 4'd5;
      bus2.cmd_rd = i[4:0];
      bus2.cmd_rn = 5'd0;
      bus2.cmd_imm = 26'(i);
      bus2.cmd_valid = 1'b1;
      cyc = 0;
      while (!bus2.cmd_ready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("wrap_accept", {31'd0, bus2.cmd_ready}, 32'd1);
      @(negedge clk);
      bus2.cmd_valid = 1'b0;
      check("wrap_valid", {31'd0, bus2.instr_valid}, 32'd1);
      check("wrap_word", bus2.instr_word, 32'h91000000 + (i << 10) + i);
      check("wrap_addr", {28'd0, bus2.instr_addr}, (i * 4) % 16);
      bus2.instr_ready = 1'b1;
      @(negedge clk);
      bus2.instr_ready = 1'b0;
    end

    // Random commands with a random consumer; one flush in the middle.
    readyMode = 2;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 11);
      case ($urandom_range(0, 2))
        0: imm = $urandom_range(0, 600) - 300;
        1: imm = int'({{6{1'b0}}, 26'($urandom)}) - (1 << 25);
        default: begin
          case ($urandom_range(0, 9))
            0: imm = -(1 << 18);
            1: imm = (1 << 18) - 1;
            2: imm = 1 << 18;
            3: imm = -(1 << 18) - 1;
            4: imm = 4095;
            5: imm = 4096;
            6: imm = -256;
            7: imm = 255;
            8: imm = 256;
            default: imm = -257;
          endcase
        end
      endcase
      model(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), imm,
            $urandom_range(0, 15), w, code);
      send(op, int'(w[4:0]), int'(w[9:5]), int'(w[20:16]), imm, int'(w[3:0]), w, code);
      if (n == 100) do_flush();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
